// File: rtl/frec_div_pkg.sv
// -----------------------------------------------------------------------------
// frec_div_pkg
// Shared definitions for the square-wave frequency divider controller.
// Holds the controller state encoding and the default width / compare value
// used when the divider comes out of reset.
// -----------------------------------------------------------------------------
package frec_div_pkg;

  // Controller states: IDLE (halted, wave low), RUN (counting),
  // PEND (counting with a new compare value waiting for the next toggle).
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2
  } DivStateT;

  // Default counter width and the compare value loaded at reset.
  localparam int DEF_WIDTH = 26;
  localparam int DEF_HALF  = 25_000_000;

endpackage

// File: rtl/frec_div_if.sv
// -----------------------------------------------------------------------------
// frec_div_if
// Valid/ready configuration port for the frequency divider.
//   iCfgValid  requester -> divider  config request valid
//   iCfgHalf   requester -> divider  requested compare value (half period N+1)
//   oCfgReady  divider -> requester  transfer happens on valid & ready
//   oCfgErr    divider -> requester  1-cycle pulse, accepted value was 0
// The master modport is the requester side, slave is the divider side.
// -----------------------------------------------------------------------------
interface frec_div_if #(
  parameter int WIDTH = 26
);

  logic             iCfgValid;
  logic [WIDTH-1:0] iCfgHalf;
  logic             oCfgReady;
  logic             oCfgErr;

  modport master (
    output iCfgValid,
    output iCfgHalf,
    input  oCfgReady,
    input  oCfgErr
  );

  modport slave (
    input  iCfgValid,
    input  iCfgHalf,
    output oCfgReady,
    output oCfgErr
  );

endinterface

// File: rtl/frec_div_core.sv
// -----------------------------------------------------------------------------
// frec_div_core
// Divide counter, compare and output toggle register.
//   iClk       system clock
//   iRst       asynchronous active-high reset
//   iEnable    count while high
//   iClear     force counter to 0 and the wave low (wins over iEnable)
//   iCompare   compare value N; the wave toggles every N+1 enabled clocks
//   oS         divided square wave
//   oTerminal  combinational, high in the cycle the counter matches iCompare
// -----------------------------------------------------------------------------
module frec_div_core
  import frec_div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iEnable,
  input  logic             iClear,
  input  logic [WIDTH-1:0] iCompare,
  output logic             oS,
  output logic             oTerminal
);

  logic [WIDTH-1:0] count;
  logic             sReg;

  // The compare value only ever changes while the counter is 0 (at a terminal
  // count or while cleared), so an equality test is enough: the counter can
  // never run past the compare value and wrap by overflow.
  assign oTerminal = iEnable & ~iClear & (count == iCompare);
  assign oS        = sReg;

  // Counter and toggle register: clear dominates, otherwise count up and on
  // a match restart from zero and flip the wave.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      count <= '0;
      sReg  <= 1'b0;
    end else if (iClear) begin
      count <= '0;
      sReg  <= 1'b0;
    end else if (oTerminal) begin
      count <= '0;
      sReg  <= ~sReg;
    end else if (iEnable) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/frec_div_ctrl.sv
// -----------------------------------------------------------------------------
// frec_div_ctrl
// Run-time controller for the square-wave frequency divider. Start/stop
// control, a valid/ready config port for the half-period compare value, and
// glitch-free switching: new values only take effect at a terminal count.
//   iClk        system clock
//   iRst        asynchronous active-high reset
//   iStart      1-cycle pulse, begin toggling (ignored while running)
//   iStop       1-cycle pulse, halt and force the wave low (wins over iStart)
//   cfg         config port (valid/ready/half/err), slave side
//   oS          divided square wave, period 2*(active+1) clocks
//   oTick       1-cycle pulse on every toggle of oS
//   oRunning    high in RUN or PEND
//   oActiveHalf compare value currently in use
// -----------------------------------------------------------------------------
module frec_div_ctrl
  import frec_div_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_HALF = WIDTH'(DEF_HALF)
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iStart,
  input  logic             iStop,
  frec_div_if.slave        cfg,
  output logic             oS,
  output logic             oTick,
  output logic             oRunning,
  output logic [WIDTH-1:0] oActiveHalf
);

  DivStateT         state;
  DivStateT         stateNext;
  logic [WIDTH-1:0] active;
  logic [WIDTH-1:0] activeNext;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pendingNext;
  logic             tickReg;
  logic             errReg;
  logic             errNext;
  logic             cfgReady;
  logic             cfgAccept;
  logic             cfgZero;
  logic             coreEnable;
  logic             coreClear;
  logic             terminal;

  // Only one value can wait for a terminal count, so the port stalls in PEND.
  assign cfgReady  = (state != PEND);
  assign cfgAccept = cfg.iCfgValid & cfgReady;
  assign cfgZero   = (cfg.iCfgHalf == '0);

  // A stop clears the core in the same cycle so the wave is low on the next
  // clock; IDLE keeps the counter parked at zero so a start always gets the
  // full first half-period.
  assign coreEnable = (state != IDLE);
  assign coreClear  = (state == IDLE) | iStop;

  frec_div_core #(
    .WIDTH (WIDTH)
  ) uCore (
    .iClk      (iClk),
    .iRst      (iRst),
    .iEnable   (coreEnable),
    .iClear    (coreClear),
    .iCompare  (active),
    .oS        (oS),
    .oTerminal (terminal)
  );

  assign cfg.oCfgReady = cfgReady;
  assign cfg.oCfgErr   = errReg;
  assign oTick         = tickReg;
  assign oRunning      = (state != IDLE);
  assign oActiveHalf   = active;

  // Next-state and register update logic. A zero compare value is rejected
  // with an error pulse and changes nothing. While running, an accepted value
  // parks in pending and only moves into active at the next terminal count
  // (or on stop), so the current half-period is never cut short.
  always_comb begin
    stateNext   = state;
    activeNext  = active;
    pendingNext = pending;
    errNext     = cfgAccept & cfgZero;
    case (state)
      IDLE: begin
        if (cfgAccept && !cfgZero) activeNext = cfg.iCfgHalf;
        if (iStart && !iStop) stateNext = RUN;
      end
      RUN: begin
        if (iStop) begin
          stateNext = IDLE;
          if (cfgAccept && !cfgZero) activeNext = cfg.iCfgHalf;
        end else if (cfgAccept && !cfgZero) begin
          pendingNext = cfg.iCfgHalf;
          stateNext   = PEND;
        end
      end
      PEND: begin
        if (iStop) begin
          stateNext  = IDLE;
          activeNext = pending;
        end else if (terminal) begin
          stateNext  = RUN;
          activeNext = pending;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // State, compare registers and the registered tick / error pulses.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state   <= IDLE;
      active  <= DEFAULT_HALF;
      pending <= '0;
      tickReg <= 1'b0;
      errReg  <= 1'b0;
    end else begin
      state   <= stateNext;
      active  <= activeNext;
      pending <= pendingNext;
      tickReg <= terminal;
      errReg  <= errNext;
    end
  end

endmodule

// File: tb/tb_frec_div_ctrl.sv
// -----------------------------------------------------------------------------
// tb_frec_div_ctrl
// Directed self-checking bench for frec_div_ctrl with default parameters.
// Inputs change 1 time unit after a rising edge, outputs are sampled there.
// -----------------------------------------------------------------------------
module tb_frec_div_ctrl;

  localparam int               WIDTH    = 26;
  localparam logic [WIDTH-1:0] DEF_HALF = 26'd25_000_000;

  logic             iClk;
  logic             iRst;
  logic             iStart;
  logic             iStop;
  logic             oS;
  logic             oTick;
  logic             oRunning;
  logic [WIDTH-1:0] oActiveHalf;

  int assertCount = 0;
  int failCount   = 0;

  frec_div_if #(.WIDTH(WIDTH)) cfgIf ();

  frec_div_ctrl #(
    .WIDTH        (WIDTH),
    .DEFAULT_HALF (DEF_HALF)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iStart      (iStart),
    .iStop       (iStop),
    .cfg         (cfgIf.slave),
    .oS          (oS),
    .oTick       (oTick),
    .oRunning    (oRunning),
    .oActiveHalf (oActiveHalf)
  );

  // 10-unit system clock.
  initial begin
    iClk = 1'b0;
    forever #5 iClk = ~iClk;
  end

  // Advance one clock and settle just after the edge.
  task automatic clk();
    @(posedge iClk);
    #1;
  endtask

  // Present a config value for exactly one clock.
  task automatic applyStimulus(input logic [WIDTH-1:0] half);
    cfgIf.iCfgValid = 1'b1;
    cfgIf.iCfgHalf  = half;
    clk();
    cfgIf.iCfgValid = 1'b0;
    cfgIf.iCfgHalf  = '0;
  endtask

  // Reset values, then 100 idle clocks without any toggle.
  task automatic test_reset();
    int toggles;
    logic lastS;
    iRst = 1'b1;
    clk();
    clk();
    iRst = 1'b0;
    clk();
    assertCount++;
    if (oS !== 1'b0) begin failCount++; $display("[TB] FAIL reset_oS got %b want 0", oS); end
    assertCount++;
    if (oTick !== 1'b0) begin failCount++; $display("[TB] FAIL reset_oTick got %b want 0", oTick); end
    assertCount++;
    if (cfgIf.oCfgReady !== 1'b1) begin failCount++; $display("[TB] FAIL reset_ready got %b want 1", cfgIf.oCfgReady); end
    assertCount++;
    if (cfgIf.oCfgErr !== 1'b0) begin failCount++; $display("[TB] FAIL reset_err got %b want 0", cfgIf.oCfgErr); end
    assertCount++;
    if (oRunning !== 1'b0) begin failCount++; $display("[TB] FAIL reset_running got %b want 0", oRunning); end
    assertCount++;
    if (oActiveHalf !== DEF_HALF) begin failCount++; $display("[TB] FAIL reset_active got %0d want %0d", oActiveHalf, DEF_HALF); end
    toggles = 0;
    lastS   = oS;
    for (int i = 0; i < 100; i++) begin
      clk();
      if (oTick !== 1'b0 || oS !== lastS) toggles++;
      lastS = oS;
    end
    assertCount++;
    if (toggles !== 0) begin failCount++; $display("[TB] FAIL idle_toggles got %0d want 0", toggles); end
  endtask

  // N=3 loaded while idle, then start: ticks at 4, 8, 12, period 8.
  task automatic test_cfg_idle_start();
    applyStimulus(26'd3);
    assertCount++;
    if (oActiveHalf !== 26'd3) begin failCount++; $display("[TB] FAIL idle_cfg_active got %0d want 3", oActiveHalf); end
    assertCount++;
    if (oRunning !== 1'b0) begin failCount++; $display("[TB] FAIL idle_cfg_running got %b want 0", oRunning); end
    iStart = 1'b1;
    clk();
    iStart = 1'b0;
    assertCount++;
    if (oRunning !== 1'b1) begin failCount++; $display("[TB] FAIL start_running got %b want 1", oRunning); end
    for (int k = 1; k <= 12; k++) begin
      clk();
      assertCount++;
      if (oTick !== ((k % 4) == 0)) begin
        failCount++; $display("[TB] FAIL n3_tick clk %0d got %b want %b", k, oTick, (k % 4) == 0);
      end
      assertCount++;
      if (oS !== ((k / 4) % 2 == 1)) begin
        failCount++; $display("[TB] FAIL n3_wave clk %0d got %b want %b", k, oS, (k / 4) % 2 == 1);
      end
    end
  endtask

  // Running N=3 (counter just restarted), request N=1: stalls until the next
  // toggle at the old rate, then ticks every 2 clocks.
  task automatic test_cfg_running();
    applyStimulus(26'd1);
    assertCount++;
    if (cfgIf.oCfgReady !== 1'b0) begin failCount++; $display("[TB] FAIL pend_ready got %b want 0", cfgIf.oCfgReady); end
    for (int k = 2; k <= 3; k++) begin
      clk();
      assertCount++;
      if (cfgIf.oCfgReady !== 1'b0 || oTick !== 1'b0 || oActiveHalf !== 26'd3) begin
        failCount++;
        $display("[TB] FAIL pend_hold clk %0d got ready=%b tick=%b active=%0d want 0 0 3", k, cfgIf.oCfgReady, oTick, oActiveHalf);
      end
    end
    clk();
    assertCount++;
    if (oTick !== 1'b1 || oS !== 1'b0) begin
      failCount++; $display("[TB] FAIL pend_toggle got tick=%b s=%b want 1 0", oTick, oS);
    end
    assertCount++;
    if (cfgIf.oCfgReady !== 1'b1) begin failCount++; $display("[TB] FAIL pend_release_ready got %b want 1", cfgIf.oCfgReady); end
    assertCount++;
    if (oActiveHalf !== 26'd1) begin failCount++; $display("[TB] FAIL pend_active got %0d want 1", oActiveHalf); end
    for (int j = 1; j <= 6; j++) begin
      clk();
      assertCount++;
      if (oTick !== ((j % 2) == 0)) begin
        failCount++; $display("[TB] FAIL n1_tick clk %0d got %b want %b", j, oTick, (j % 2) == 0);
      end
    end
  endtask

  // Zero request while running: one error pulse, nothing else changes.
  task automatic test_cfg_zero();
    applyStimulus(26'd0);
    assertCount++;
    if (cfgIf.oCfgErr !== 1'b1) begin failCount++; $display("[TB] FAIL zero_err got %b want 1", cfgIf.oCfgErr); end
    assertCount++;
    if (oActiveHalf !== 26'd1) begin failCount++; $display("[TB] FAIL zero_active got %0d want 1", oActiveHalf); end
    assertCount++;
    if (cfgIf.oCfgReady !== 1'b1 || oRunning !== 1'b1) begin
      failCount++; $display("[TB] FAIL zero_state got ready=%b running=%b want 1 1", cfgIf.oCfgReady, oRunning);
    end
    clk();
    assertCount++;
    if (cfgIf.oCfgErr !== 1'b0) begin failCount++; $display("[TB] FAIL zero_err_pulse got %b want 0", cfgIf.oCfgErr); end
  endtask

  // Stop, simultaneous start/stop in IDLE, stop mid-count and restart.
  task automatic test_start_stop();
    iStop = 1'b1;
    clk();
    iStop = 1'b0;
    assertCount++;
    if (oS !== 1'b0 || oRunning !== 1'b0) begin
      failCount++; $display("[TB] FAIL stop_run got s=%b running=%b want 0 0", oS, oRunning);
    end
    applyStimulus(26'd3);
    iStart = 1'b1;
    iStop  = 1'b1;
    clk();
    iStart = 1'b0;
    iStop  = 1'b0;
    clk();
    assertCount++;
    if (oRunning !== 1'b0 || oS !== 1'b0) begin
      failCount++; $display("[TB] FAIL start_stop_idle got running=%b s=%b want 0 0", oRunning, oS);
    end
    iStart = 1'b1;
    clk();
    iStart = 1'b0;
    for (int k = 1; k <= 6; k++) clk();
    assertCount++;
    if (oS !== 1'b1) begin failCount++; $display("[TB] FAIL midcount_wave got %b want 1", oS); end
    iStop = 1'b1;
    clk();
    iStop = 1'b0;
    assertCount++;
    if (oS !== 1'b0 || oRunning !== 1'b0 || oTick !== 1'b0) begin
      failCount++; $display("[TB] FAIL midcount_stop got s=%b running=%b tick=%b want 0 0 0", oS, oRunning, oTick);
    end
    iStart = 1'b1;
    clk();
    iStart = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      clk();
      assertCount++;
      if (oTick !== (k == 4) || oS !== (k == 4)) begin
        failCount++; $display("[TB] FAIL restart clk %0d got tick=%b s=%b want %b %b", k, oTick, oS, k == 4, k == 4);
      end
    end
  endtask

  // Asynchronous reset while a value is pending.
  task automatic test_reset_pend();
    iStop = 1'b1;
    clk();
    iStop = 1'b0;
    applyStimulus(26'd5);
    iStart = 1'b1;
    clk();
    iStart = 1'b0;
    for (int k = 1; k <= 7; k++) clk();
    applyStimulus(26'd2);
    assertCount++;
    if (cfgIf.oCfgReady !== 1'b0 || oS !== 1'b1) begin
      failCount++; $display("[TB] FAIL pre_reset got ready=%b s=%b want 0 1", cfgIf.oCfgReady, oS);
    end
    #2;
    iRst = 1'b1;
    #1;
    assertCount++;
    if (oS !== 1'b0 || oTick !== 1'b0 || oRunning !== 1'b0 || cfgIf.oCfgReady !== 1'b1 || oActiveHalf !== DEF_HALF) begin
      failCount++;
      $display("[TB] FAIL async_reset got s=%b tick=%b running=%b ready=%b active=%0d want 0 0 0 1 %0d",
               oS, oTick, oRunning, cfgIf.oCfgReady, oActiveHalf, DEF_HALF);
    end
    clk();
    iRst = 1'b0;
    for (int k = 0; k < 8; k++) clk();
    assertCount++;
    if (oActiveHalf !== DEF_HALF || cfgIf.oCfgReady !== 1'b1 || oRunning !== 1'b0 || oS !== 1'b0) begin
      failCount++;
      $display("[TB] FAIL post_reset got active=%0d ready=%b running=%b s=%b want %0d 1 0 0",
               oActiveHalf, cfgIf.oCfgReady, oRunning, oS, DEF_HALF);
    end
  endtask

  initial begin
    iRst            = 1'b1;
    iStart          = 1'b0;
    iStop           = 1'b0;
    cfgIf.iCfgValid = 1'b0;
    cfgIf.iCfgHalf  = '0;
    test_reset();
    test_cfg_idle_start();
    test_cfg_running();
    test_cfg_zero();
    test_start_stop();
    test_reset_pend();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
